dpr_weight_loader: RTL and testbench

- Upstream write-port driver for the bank of P weight DPRs.
- Accepts a valid/ready stream of weight elements and scatters them round-robin across the P DPRs: element k goes to DPR (k mod P) at address (k div P).
- Drives the shared write address/data/we and a one-hot chip-select vector.
- Signals completion so the read side may start.

---
 rtl/dpr_pkg.sv | 18 +
 rtl/dpr_lane_row_cnt.sv | 39 +++
 rtl/dpr_weight_loader.sv | 121 ++++++++++++
 tb/tb_dpr_weight_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr_pkg.sv
// Shared constants and types for the weight DPR bank: loader, bank and read
// sequencer all size themselves from here.
package dpr_pkg;
  localparam int P            = 4;
  localparam int FEATURE_BITS = 4;
  localparam int ELEMENT_BITS = 8;
  localparam int RAM_DEPTH    = 27;
  localparam int ADDR_BITS    = 2 * FEATURE_BITS;
  localparam int CAP          = P * RAM_DEPTH;
  localparam int LEN_BITS     = $clog2(CAP + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dpr_lane_row_cnt.sv
// Round-robin lane counter (mod P) with a row counter that advances each time
// the lane wraps; element k lands on lane k mod P, row k div P.
module dpr_lane_row_cnt #(
  parameter int P      = 4,
  parameter int LANE_W = 2,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [LANE_W-1:0] o_lane,
  output logic [ROW_W-1:0]  o_row
);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(P - 1);

  logic [LANE_W-1:0] r_lane;
  logic [ROW_W-1:0]  r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_row  <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_row  <= '0;
    end else if (i_inc) begin
      if (r_lane == LAST_LANE) begin
        r_lane <= '0;
        r_row  <= r_row + 1'b1;
      end else begin
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  assign o_lane = r_lane;
  assign o_row  = r_row;
endmodule

// File: rtl/dpr_weight_loader.sv
// Write-port driver for the weight DPR bank: scatters a valid/ready element
// stream round-robin across the P DPRs and pulses done when the load is in.
module dpr_weight_loader
  import dpr_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [LEN_BITS-1:0]     load_len,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic [ELEMENT_BITS-1:0] s_data,
  output logic                    s_ready,
  output logic [ADDR_BITS-1:0]    address_in,
  output logic [ELEMENT_BITS-1:0] data_in,
  output logic                    we_in,
  output logic [P-1:0]            cs_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int                LANE_W = idx_bits(P);
  localparam logic [LEN_BITS-1:0] CAP_L = LEN_BITS'(CAP);

  loader_state               r_state, w_state_nxt;
  logic [LEN_BITS-1:0]       r_len, r_cnt;
  logic [LANE_W-1:0]         w_lane;
  logic [ADDR_BITS-1:0]      w_row;
  logic                      w_hs, w_last, w_clr, w_err;
  logic                      r_we, r_err;
  logic [P-1:0]              r_cs;
  logic [ADDR_BITS-1:0]      r_addr;
  logic [ELEMENT_BITS-1:0]   r_data;

  // Ready depends only on state so upstream never sees a comb loop via s_valid.
  assign s_ready = (r_state == LOAD);
  assign busy    = (r_state == LOAD);
  assign done    = (r_state == DONE);
  assign w_hs    = s_valid & s_ready;
  assign w_last  = ((r_cnt + 1'b1) == r_len);

  dpr_lane_row_cnt #(
    .P      (P),
    .LANE_W (LANE_W),
    .ROW_W  (ADDR_BITS)
  ) u_lane_row_cnt (
    .clk    (sys_clk),
    .rst_n  (reset_n),
    .i_clr  (w_clr),
    .i_inc  (w_hs),
    .o_lane (w_lane),
    .o_row  (w_row)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (load_len == '0) begin
            w_state_nxt = DONE;
          end else if (load_len > CAP_L) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = LOAD;
            w_clr       = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort)               w_state_nxt = IDLE;
        else if (w_hs && w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_clr) begin
        r_len <= load_len;
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Write port is registered; address/data hold between writes, cs/we drop.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_cs   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_hs;
      r_cs <= w_hs ? (P'(1) << w_lane) : '0;
      if (w_hs) begin
        r_addr <= w_row;
        r_data <= s_data;
      end
    end
  end

  assign we_in      = r_we;
  assign cs_in      = r_cs;
  assign address_in = r_addr;
  assign data_in    = r_data;
  assign err        = r_err;
endmodule

// File: tb/tb_dpr_weight_loader.sv
// Bench for dpr_weight_loader: random-ish streams checked against a k mod P /
// k div P scatter model, plus zero/overflow/abort/reset/back-to-back cases.
module tb_dpr_weight_loader;
  import dpr_pkg::*;

  logic                    sys_clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    start = 1'b0;
  logic [LEN_BITS-1:0]     load_len = '0;
  logic                    abort = 1'b0;
  logic                    s_valid = 1'b0;
  logic [ELEMENT_BITS-1:0] s_data = '0;
  logic                    s_ready, we_in, busy, done, err;
  logic [ADDR_BITS-1:0]    address_in;
  logic [ELEMENT_BITS-1:0] data_in;
  logic [P-1:0]            cs_in;

  dpr_weight_loader dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .load_len(load_len),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .address_in(address_in), .data_in(data_in), .we_in(we_in), .cs_in(cs_in),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int                      cyc;
    logic [P-1:0]            cs;
    logic [ADDR_BITS-1:0]    addr;
    logic [ELEMENT_BITS-1:0] data;
    logic                    busy;
  } wr_t;

  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  wr_t wq[$];
  int  done_q[$];
  int  err_q[$];
  logic [ELEMENT_BITS-1:0] din[$];
  logic [ADDR_BITS-1:0]    last_a = '0;
  logic [ELEMENT_BITS-1:0] last_d = '0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: logs writes/done/err; between writes cs must be 0 and addr/data hold.
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      last_a = '0;
      last_d = '0;
    end else if (we_in) begin
      wr_t w;
      w.cyc = cyc; w.cs = cs_in; w.addr = address_in; w.data = data_in; w.busy = busy;
      wq.push_back(w);
      last_a = address_in;
      last_d = data_in;
    end else begin
      checks++;
      if (cs_in !== '0 || address_in !== last_a || data_in !== last_d) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got cs=%b addr=%0d data=%0d expected cs=0 addr=%0d data=%0d",
                 cyc, cs_in, address_in, data_in, last_a, last_d);
      end
    end
    if (done) done_q.push_back(cyc);
    if (err)  err_q.push_back(cyc);
  end

  // Reference: element k goes to DPR k mod P at address k div P.
  function automatic wr_t exp_wr(input int k, input logic [ELEMENT_BITS-1:0] d);
    wr_t e;
    e.cyc = 0; e.busy = 1'b0;
    e.cs   = P'(1) << (k % P);
    e.addr = ADDR_BITS'(k / P);
    e.data = d;
    return e;
  endfunction

  task automatic clear_logs();
    wq.delete(); done_q.delete(); err_q.delete();
  endtask

  task automatic do_start(input int len);
    @(negedge sys_clk);
    start = 1'b1; load_len = LEN_BITS'(len); start_cyc = cyc;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // mode 0: valid always, 1: every other cycle, 2: random
  task automatic drive_stream(input int n, input int mode);
    int idx = 0, budget = 0;
    bit v, hs;
    while (idx < n && budget < 40 * n + 50) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 1) == 1);
      s_valid = v;
      s_data  = din[idx];
      hs = v && (s_ready === 1'b1);
      @(posedge sys_clk);
      if (hs) idx++;
      budget++;
      @(negedge sys_clk);
    end
    s_valid = 1'b0;
    checks++;
    if (idx != n) begin
      failures++;
      $display("FAIL stream_timeout accepted=%0d expected=%0d", idx, n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({s_ready, we_in, cs_in, address_in, data_in, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b we=%b cs=%b addr=%0d data=%0d busy=%b done=%b err=%b expected all 0",
               s_ready, we_in, cs_in, address_in, data_in, busy, done, err);
    end
    @(negedge sys_clk); reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({s_ready, we_in, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got ready=%b we=%b busy=%b done=%b err=%b expected all 0",
               s_ready, we_in, busy, done, err);
    end
  endtask

  task automatic test_load(input string tag, input int len, input int mode);
    int last_cyc;
    wr_t e;
    clear_logs();
    do_start(len);
    drive_stream(len, mode);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wq.size() != len) begin
      failures++;
      $display("FAIL %s_count got=%0d expected=%0d", tag, wq.size(), len);
    end
    for (int k = 0; k < wq.size() && k < len; k++) begin
      e = exp_wr(k, din[k]);
      checks++;
      if (wq[k].cs !== e.cs || wq[k].addr !== e.addr || wq[k].data !== e.data) begin
        failures++;
        $display("FAIL %s_wr%0d got cs=%b addr=%0d data=%0d expected cs=%b addr=%0d data=%0d",
                 tag, k, wq[k].cs, wq[k].addr, wq[k].data, e.cs, e.addr, e.data);
      end
    end
    last_cyc = (wq.size() > 0) ? wq[wq.size()-1].cyc : -1;
    checks++;
    if (done_q.size() != 1 || done_q[0] != last_cyc) begin
      failures++;
      $display("FAIL %s_done_timing got pulses=%0d first=%0d expected 1 pulse at cyc=%0d",
               tag, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, last_cyc);
    end
    checks++;
    if (wq.size() > 0 && wq[wq.size()-1].busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_last got=%b expected=0", tag, wq[wq.size()-1].busy);
    end
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || err_q.size() != 0) begin
      failures++;
      $display("FAIL %s_end_idle got busy=%b ready=%b errs=%0d expected 0 0 0", tag, busy, s_ready, err_q.size());
    end
  endtask

  task automatic test_basic();
    din.delete();
    for (int k = 0; k < 6; k++) din.push_back(ELEMENT_BITS'(10 + k));
    test_load("basic", 6, 0);
  endtask

  task automatic test_gaps();
    din.delete();
    for (int k = 0; k < 6; k++) din.push_back(ELEMENT_BITS'(10 + k));
    test_load("gaps", 6, 1);
  endtask

  task automatic test_zero_len();
    clear_logs();
    do_start(0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wq.size() != 0 || done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != start_cyc + 1)) begin
      failures++;
      $display("FAIL zero_len got writes=%0d dones=%0d first_done=%0d expected 0 writes, done at cyc=%0d",
               wq.size(), done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, start_cyc + 1);
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    do_start(CAP + 1);
    checks++;
    if (err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overflow_err got err=%b ready=%b busy=%b expected 1 0 0", err, s_ready, busy);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wq.size() != 0 || done_q.size() != 0 || err_q.size() != 1 || (err_q.size() > 0 && err_q[0] != start_cyc + 1)) begin
      failures++;
      $display("FAIL overflow_side got writes=%0d dones=%0d errs=%0d expected 0 0 1 at cyc=%0d",
               wq.size(), done_q.size(), err_q.size(), start_cyc + 1);
    end
  endtask

  task automatic test_full();
    din.delete();
    for (int k = 0; k < CAP; k++) din.push_back(ELEMENT_BITS'(k % 256));
    test_load("full", CAP, 0);
    checks++;
    if (wq.size() == 0 || wq[wq.size()-1].cs !== 4'b1000 || wq[wq.size()-1].addr !== 8'd26 ||
        wq[wq.size()-1].data !== 8'd107) begin
      failures++;
      $display("FAIL full_last_write got cs=%b addr=%0d data=%0d expected cs=1000 addr=26 data=107",
               (wq.size() > 0) ? wq[wq.size()-1].cs : '0, (wq.size() > 0) ? wq[wq.size()-1].addr : '0,
               (wq.size() > 0) ? wq[wq.size()-1].data : '0);
    end
  endtask

  task automatic test_abort();
    wr_t e;
    din.delete();
    for (int k = 0; k < 10; k++) din.push_back(ELEMENT_BITS'($urandom));
    clear_logs();
    do_start(10);
    drive_stream(3, 0);
    abort = 1'b1;
    @(negedge sys_clk); abort = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wq.size() != 3 || done_q.size() != 0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got writes=%0d dones=%0d ready=%b expected 3 0 0", wq.size(), done_q.size(), s_ready);
    end
    for (int k = 0; k < wq.size() && k < 3; k++) begin
      e = exp_wr(k, din[k]);
      checks++;
      if (wq[k].cs !== e.cs || wq[k].addr !== e.addr || wq[k].data !== e.data) begin
        failures++;
        $display("FAIL abort_wr%0d got cs=%b addr=%0d data=%0d expected cs=%b addr=%0d data=%0d",
                 k, wq[k].cs, wq[k].addr, wq[k].data, e.cs, e.addr, e.data);
      end
    end
    // abort together with a handshake: that element is still written
    clear_logs();
    do_start(5);
    drive_stream(1, 0);
    s_valid = 1'b1; s_data = din[1]; abort = 1'b1;
    @(negedge sys_clk); abort = 1'b0; s_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    e = exp_wr(1, din[1]);
    checks++;
    if (wq.size() != 2 || done_q.size() != 0 ||
        (wq.size() == 2 && (wq[1].cs !== e.cs || wq[1].addr !== e.addr || wq[1].data !== e.data))) begin
      failures++;
      $display("FAIL abort_same_cycle got writes=%0d dones=%0d expected 2 writes (last cs=%b data=%0d) 0 dones",
               wq.size(), done_q.size(), e.cs, e.data);
    end
    din.delete();
    din.push_back(8'hA5); din.push_back(8'h5A);
    test_load("after_abort", 2, 0);
  endtask

  task automatic test_reset_midload();
    int n_before;
    din.delete();
    for (int k = 0; k < 10; k++) din.push_back(ELEMENT_BITS'($urandom));
    clear_logs();
    do_start(10);
    drive_stream(5, 0);
    @(negedge sys_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, we_in, cs_in, address_in, data_in, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL midload_reset got ready=%b we=%b cs=%b addr=%0d data=%0d busy=%b done=%b err=%b expected all 0",
               s_ready, we_in, cs_in, address_in, data_in, busy, done, err);
    end
    n_before = wq.size();
    checks++;
    if (n_before != 5) begin
      failures++;
      $display("FAIL midload_prewrites got=%0d expected=5", n_before);
    end
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h3C;
    repeat (6) @(negedge sys_clk);
    s_valid = 1'b0;
    checks++;
    if (wq.size() != n_before || done_q.size() != 0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL midload_release got writes=%0d dones=%0d ready=%b expected %0d 0 0",
               wq.size(), done_q.size(), s_ready, n_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [ELEMENT_BITS-1:0] a[$];
    wr_t e;
    clear_logs();
    din.delete();
    for (int k = 0; k < 3; k++) din.push_back(ELEMENT_BITS'($urandom));
    a = din;
    do_start(3);
    drive_stream(3, 0);
    din.delete();
    for (int k = 0; k < 5; k++) din.push_back(ELEMENT_BITS'($urandom));
    do_start(5);
    drive_stream(5, 0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (wq.size() != 8 || done_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count got writes=%0d dones=%0d expected 8 2", wq.size(), done_q.size());
    end
    for (int k = 0; k < wq.size() && k < 8; k++) begin
      e = (k < 3) ? exp_wr(k, a[k]) : exp_wr(k - 3, din[k - 3]);
      checks++;
      if (wq[k].cs !== e.cs || wq[k].addr !== e.addr || wq[k].data !== e.data) begin
        failures++;
        $display("FAIL b2b_wr%0d got cs=%b addr=%0d data=%0d expected cs=%b addr=%0d data=%0d",
                 k, wq[k].cs, wq[k].addr, wq[k].data, e.cs, e.addr, e.data);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, CAP);
      din.delete();
      for (int k = 0; k < len; k++) din.push_back(ELEMENT_BITS'($urandom));
      test_load("random", len, 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_overflow();
    test_full();
    test_abort();
    test_reset_midload();
    test_basic();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
